// File: rtl/led_pattern_gen_if.sv
// LED pattern generator bus: mode request/load in, LED drive, tick strobe and
// active mode out. The generator connects via the slave modport and the
// controller via the master modport.
interface led_pattern_if #(
  parameter int NUM_LEDS = 5
);
  logic [1:0]          mode_in;
  logic                mode_ld;
  logic [NUM_LEDS-1:0] leds;
  logic                tick;
  logic [1:0]          mode;

  modport master (
    output mode_in,
    output mode_ld,
    input  leds,
    input  tick,
    input  mode
  );

  modport slave (
    input  mode_in,
    input  mode_ld,
    output leds,
    output tick,
    output mode
  );
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: parametrised LED driver for board bring-up.
// A free-running prescaler produces a slow tick that steps a pattern engine:
// binary COUNT, rotating CHASE, BOUNCE, or PWM BREATHE.
// Optional feature macro: LED_BREATHE_EN builds the BREATHE mode (duty triangle
// and PWM compare). Without it, a load request for mode 3 is ignored entirely.
module led_pattern_gen #(
  parameter int NUM_LEDS   = 5,
  parameter int PRESCALE_W = 22,
  parameter int PWM_W      = 8
) (
  input  logic          clk,
  input  logic          rst,
  led_pattern_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam logic [NUM_LEDS-1:0]   PAT_ONE = NUM_LEDS'(1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

  // Reject configurations the PWM compare and LED vector cannot support.
  if (PWM_W >= PRESCALE_W || PWM_W < 1 || NUM_LEDS < 1) begin : g_bad_params
    $error("led_pattern_gen: need NUM_LEDS>=1 and 1<=PWM_W<PRESCALE_W");
  end

  logic [PRESCALE_W-1:0] pre_r, pre_nxt_s;
  mode_t                 mode_r, mode_nxt_s;
  logic [NUM_LEDS-1:0]   pat_r, pat_nxt_s;
  logic [NUM_LEDS-1:0]   leds_r, leds_nxt_s;
  logic                  dir_up_r, dir_up_nxt_s;
  logic                  tick_s;
  logic                  load_s;
`ifdef LED_BREATHE_EN
  logic [PWM_W-1:0]      duty_r, duty_nxt_s;
  logic                  pwm_on_s;
`endif

  // Tick is a pure decode of the prescaler so it lines up with its wrap.
  assign tick_s = &pre_r;

  // Decide whether the load request is honoured; mode 3 needs the PWM engine.
  always_comb begin
`ifdef LED_BREATHE_EN
    load_s = bus.mode_ld;
`else
    load_s = bus.mode_ld && (bus.mode_in != 2'd3);
`endif
  end

`ifdef LED_BREATHE_EN
  // PWM compare: LEDs lit while the low prescaler bits are below the duty.
  always_comb begin
    pwm_on_s = (pre_r[PWM_W-1:0] < duty_r);
  end
`endif

  // Next-state logic: load beats tick; tick steps the active pattern.
  always_comb begin
    pre_nxt_s    = pre_r + PRE_ONE;
    mode_nxt_s   = mode_r;
    pat_nxt_s    = pat_r;
    dir_up_nxt_s = dir_up_r;
`ifdef LED_BREATHE_EN
    duty_nxt_s   = duty_r;
`endif
    if (load_s) begin
      pre_nxt_s    = '0;
      mode_nxt_s   = mode_t'(bus.mode_in);
      dir_up_nxt_s = 1'b1;
`ifdef LED_BREATHE_EN
      duty_nxt_s   = '0;
`endif
      case (mode_t'(bus.mode_in))
        MODE_CHASE, MODE_BOUNCE: pat_nxt_s = PAT_ONE;
        default:                 pat_nxt_s = '0;
      endcase
    end else if (tick_s) begin
      case (mode_r)
        MODE_COUNT: pat_nxt_s = pat_r + PAT_ONE;
        // Rotate left; the right shift brings the MSB around to bit 0.
        MODE_CHASE: pat_nxt_s = (pat_r << 1) | (pat_r >> (NUM_LEDS - 1));
        MODE_BOUNCE: begin
          if (NUM_LEDS == 1) begin
            pat_nxt_s = pat_r;
          end else if (dir_up_r) begin
            pat_nxt_s    = pat_r << 1;
            dir_up_nxt_s = ~pat_nxt_s[NUM_LEDS-1];
          end else begin
            pat_nxt_s    = pat_r >> 1;
            dir_up_nxt_s = pat_nxt_s[0];
          end
        end
`ifdef LED_BREATHE_EN
        // Triangle: turn around at each end without repeating the end value.
        MODE_BREATHE: begin
          if (dir_up_r) begin
            if (&duty_r) begin
              duty_nxt_s   = duty_r - PWM_W'(1);
              dir_up_nxt_s = 1'b0;
            end else begin
              duty_nxt_s   = duty_r + PWM_W'(1);
            end
          end else begin
            if (duty_r == '0) begin
              duty_nxt_s   = duty_r + PWM_W'(1);
              dir_up_nxt_s = 1'b1;
            end else begin
              duty_nxt_s   = duty_r - PWM_W'(1);
            end
          end
        end
`endif
        default: pat_nxt_s = pat_r;
      endcase
    end else begin
      pat_nxt_s = pat_r;
    end

`ifdef LED_BREATHE_EN
    if (!load_s && mode_r == MODE_BREATHE) begin
      leds_nxt_s = {NUM_LEDS{pwm_on_s}};
    end else begin
      leds_nxt_s = pat_nxt_s;
    end
`else
    leds_nxt_s = pat_nxt_s;
`endif
  end

  // State and output registers with asynchronous reset to COUNT at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r    <= '0;
      mode_r   <= MODE_COUNT;
      pat_r    <= '0;
      leds_r   <= '0;
      dir_up_r <= 1'b1;
`ifdef LED_BREATHE_EN
      duty_r   <= '0;
`endif
    end else begin
      pre_r    <= pre_nxt_s;
      mode_r   <= mode_nxt_s;
      pat_r    <= pat_nxt_s;
      leds_r   <= leds_nxt_s;
      dir_up_r <= dir_up_nxt_s;
`ifdef LED_BREATHE_EN
      duty_r   <= duty_nxt_s;
`endif
    end
  end

  assign bus.leds = leds_r;
  assign bus.tick = tick_s;
  assign bus.mode = mode_r;

endmodule
